// File: rtl/epl_pkg.sv
// epl_pkg: shared Powerlink SoC framing constants, FSM states and frame-byte lookup.
package epl_pkg;
    localparam logic [47:0] SOC_MAC     = 48'h01_11_1E_00_00_01;
    localparam logic [15:0] ETHERTYPE   = 16'h88AB;
    localparam logic [7:0]  MSG_SOC     = 8'h01;
    localparam logic [7:0]  DST_NODE    = 8'hFF;
    localparam logic [7:0]  SRC_NODE    = 8'hF0;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [6:0]  NETTIME_OFS = 7'd20;
    localparam logic [6:0]  RELTIME_OFS = 7'd28;
    localparam logic [6:0]  DATA_LEN    = 7'd60;
    localparam logic [6:0]  PRE_LEN     = 7'd8;
    localparam logic [6:0]  FCS_LEN     = 7'd4;
    localparam logic [6:0]  IFG_LEN     = 7'd12;

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_FCS, ST_IFG} tx_state_t;

    function automatic logic [7:0] soc_byte(input logic [6:0] idx, input logic [47:0] mac,
                                            input logic [63:0] nt, input logic [63:0] rt);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 7'd6) b = 8'(SOC_MAC >> (8 * (7'd5 - idx)));
        else if (idx < 7'd12) b = 8'(mac >> (8 * (7'd11 - idx)));
        else if (idx == 7'd12) b = ETHERTYPE[15:8];
        else if (idx == 7'd13) b = ETHERTYPE[7:0];
        else if (idx == 7'd14) b = MSG_SOC;
        else if (idx == 7'd15) b = DST_NODE;
        else if (idx == 7'd16) b = SRC_NODE;
        else if (idx >= NETTIME_OFS && idx < RELTIME_OFS) b = 8'(nt >> (8 * (idx - NETTIME_OFS)));
        else if (idx >= RELTIME_OFS && idx < RELTIME_OFS + 7'd8) b = 8'(rt >> (8 * (idx - RELTIME_OFS)));
        return b;
    endfunction
endpackage

// File: rtl/crc32_dibit.sv
// crc32_dibit: reflected CRC-32 register advancing two bits (d[0] first) per enabled clock.
module crc32_dibit
    import epl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);
    logic [31:0] c1, c2;

    always_comb begin
        c1 = (crc >> 1) ^ ((crc[0] ^ d[0]) ? CRC_POLY : 32'h0);
        c2 = (c1 >> 1) ^ ((c1[0] ^ d[1]) ? CRC_POLY : 32'h0);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) crc <= CRC_INIT;
        else if (clr) crc <= CRC_INIT;
        else if (en) crc <= c2;
endmodule

// File: rtl/soc_frame_gen.sv
// soc_frame_gen: periodic Powerlink SoC frame generator driving RMII transmit dibits.
module soc_frame_gen
    import epl_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h00_50_C2_00_00_F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fast_eth,
    input  logic [31:0] cycle_len,
    input  logic [31:0] cycle_ns,
    input  logic [63:0] net_time,
    output logic        rm_tx_en,
    output logic [1:0]  rm_tx_data,
    output logic        busy,
    output logic        soc_sent,
    output logic        overrun
);
    tx_state_t   state, ns;
    logic [31:0] cnt, cl, crc;
    logic [63:0] rel, nt_q, rt_q;
    logic [6:0]  byte_cnt, nb, last_byte;
    logic [1:0]  dib, nd, dout;
    logic [3:0]  slot;
    logic [7:0]  bval;
    logic        fast_q, trig, start, slot_end, adv, end_state;

    assign cl    = (cycle_len == 32'd0) ? 32'd1 : cycle_len;
    assign trig  = enable && cnt == 32'd0;
    assign start = trig && state == ST_IDLE;
    assign busy  = state != ST_IDLE;

    // Everything below looks one dibit ahead: it describes the position loaded on the next slot edge.
    always_comb begin
        slot_end  = fast_q || slot == 4'd9;
        last_byte = state == ST_PRE ? PRE_LEN - 7'd1 : state == ST_DATA ? DATA_LEN - 7'd1 :
                    state == ST_FCS ? FCS_LEN - 7'd1 : IFG_LEN - 7'd1;
        adv       = slot_end && dib == 2'd3;
        end_state = adv && byte_cnt == last_byte;
        ns        = !end_state ? state : state == ST_PRE ? ST_DATA : state == ST_DATA ? ST_FCS :
                    state == ST_FCS ? ST_IFG : ST_IDLE;
        nb        = end_state ? 7'd0 : adv ? byte_cnt + 7'd1 : byte_cnt;
        nd        = slot_end ? dib + 2'd1 : dib;
        bval      = ns == ST_PRE  ? (nb == PRE_LEN - 7'd1 ? 8'hD5 : 8'h55) :
                    ns == ST_DATA ? soc_byte(nb, SRC_MAC, nt_q, rt_q) :
                    ns == ST_FCS  ? 8'(~crc >> (8 * nb)) : 8'h00;
        dout      = 2'(bval >> (2 * nd));
    end

    crc32_dibit u_crc (
        .clk(clk), .rst(rst), .clr(start),
        .en(busy && slot_end && ns == ST_DATA), .d(dout), .crc(crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            rel <= '0;
            nt_q <= '0;
            rt_q <= '0;
            byte_cnt <= '0;
            dib <= '0;
            slot <= '0;
            fast_q <= 1'b0;
            rm_tx_en <= 1'b0;
            rm_tx_data <= 2'b00;
            soc_sent <= 1'b0;
            overrun <= 1'b0;
        end else begin
            cnt <= !enable ? 32'd0 : (cnt >= cl - 32'd1) ? 32'd0 : cnt + 32'd1;
            soc_sent <= 1'b0;
            overrun <= trig && busy;
            if (trig) rel <= rel + {32'd0, cycle_ns};
            if (start) begin
                state <= ST_PRE;
                byte_cnt <= '0;
                dib <= '0;
                slot <= '0;
                fast_q <= fast_eth;
                nt_q <= net_time;
                rt_q <= rel;
                rm_tx_en <= 1'b1;
                rm_tx_data <= 2'b01;
            end else if (busy) begin
                slot <= slot_end ? 4'd0 : slot + 4'd1;
                if (slot_end) begin
                    state <= ns;
                    byte_cnt <= nb;
                    dib <= nd;
                    rm_tx_en <= ns == ST_PRE || ns == ST_DATA || ns == ST_FCS;
                    rm_tx_data <= dout;
                    soc_sent <= state == ST_FCS && ns == ST_IFG;
                end
            end
        end
    end
endmodule

// File: tb/tb_soc_frame_gen.sv
// tb_soc_frame_gen: randomized checks of soc_frame_gen against a trigger/busy scheduling and byte-level frame model.
module tb_soc_frame_gen;
    localparam int MAXC = 8192;
    logic clk = 0, rst = 0, enable = 0, fast_eth = 0;
    logic [31:0] cycle_len = 0, cycle_ns = 0;
    logic [63:0] net_time = 0;
    logic rm_tx_en, busy, soc_sent, overrun;
    logic [1:0] rm_tx_data;
    int checks = 0, errors = 0, cyc = 0;
    logic en_l [MAXC];
    logic [1:0] d_l [MAXC];
    logic b_l [MAXC], s_l [MAXC], o_l [MAXC];
    logic [7:0] exp_f [72];
    logic [63:0] nts [400];
    logic [63:0] nt_base;
    logic [7:0] hdr [20] = '{8'h01, 8'h11, 8'h1E, 8'h00, 8'h00, 8'h01, 8'h00, 8'h50, 8'hC2, 8'h00,
                             8'h00, 8'hF0, 8'h88, 8'hAB, 8'h01, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00};
    logic [7:0] nt_bytes [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

    soc_frame_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .fast_eth(fast_eth), .cycle_len(cycle_len),
        .cycle_ns(cycle_ns), .net_time(net_time), .rm_tx_en(rm_tx_en), .rm_tx_data(rm_tx_data),
        .busy(busy), .soc_sent(soc_sent), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk)
        if (rst && cyc < MAXC) begin
            en_l[cyc] <= rm_tx_en;
            d_l[cyc] <= rm_tx_data;
            b_l[cyc] <= busy;
            s_l[cyc] <= soc_sent;
            o_l[cyc] <= overrun;
        end

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) begin
            $display("FAIL wait_cyc reached %0d required %0d", cyc, k);
            $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
            $fatal(1, "timeout");
        end
    endtask

    task automatic build_frame(input logic [63:0] nt, input logic [63:0] rt);
        logic [31:0] c;
        for (int i = 0; i < 7; i++) exp_f[i] = 8'h55;
        exp_f[7] = 8'hD5;
        for (int i = 0; i < 60; i++) begin
            if (i < 20) exp_f[8 + i] = hdr[i];
            else if (i < 28) exp_f[8 + i] = nt[8 * (i - 20) +: 8];
            else if (i < 36) exp_f[8 + i] = rt[8 * (i - 28) +: 8];
            else exp_f[8 + i] = 8'h00;
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 68; i++) begin
            c ^= {24'h0, exp_f[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        for (int i = 0; i < 4; i++) exp_f[68 + i] = ~c[8 * i +: 8];
    endtask

    function automatic logic [7:0] obs_byte(input int s, input int step, input int j);
        logic [7:0] b;
        for (int q = 0; q < 4; q++) b[2 * q +: 2] = d_l[s + (4 * j + q) * step];
        return b;
    endfunction

    task automatic run_check(input string name, input int len, input logic [31:0] ns, input bit fast,
                             input int ntrig, input bit vary);
        int leff, step, flen, dlen, e, free, t, j, nidle, nbad, first, nmis;
        logic [63:0] rel_m, got;
        logic [7:0] eb;
        logic [1:0] ed;
        int es [$], eo [$], os [$], ol [$], oo [$], osent [$];
        logic [63:0] er [$], enq [$];
        leff = (len == 0) ? 1 : len;
        step = fast ? 1 : 10;
        flen = 288 * step;
        dlen = 336 * step;
        e = (ntrig - 1) * leff + dlen + 20;
        for (int k = 0; k < ntrig; k++) nts[k] = vary ? {$urandom, $urandom} : nt_base;
        rst = 0;
        enable = 1;
        fast_eth = fast;
        cycle_len = len;
        cycle_ns = ns;
        net_time = nts[0];
        repeat (2) @(negedge clk);
        for (int i = 0; i < MAXC; i++) begin
            en_l[i] = 0; d_l[i] = 0; b_l[i] = 0; s_l[i] = 0; o_l[i] = 0;
        end
        #2 rst = 1;
        for (int k = 1; k < ntrig; k++) begin
            wait_cyc(k * leff);
            net_time = nts[k];
        end
        wait_cyc((ntrig - 1) * leff + 1);
        enable = 0;
        wait_cyc(e);
        free = 0;
        rel_m = 0;
        for (int k = 0; k < ntrig; k++) begin
            t = k * leff;
            if (t >= free) begin
                es.push_back(t + 1);
                er.push_back(rel_m);
                enq.push_back(nts[k]);
                free = t + dlen + 1;
            end else eo.push_back(t + 1);
            rel_m += {32'h0, ns};
        end
        nidle = 0;
        for (int i = 1; i < e; i++) begin
            if (en_l[i] && !en_l[i - 1]) begin
                j = i;
                while (j < e && en_l[j]) j++;
                os.push_back(i);
                ol.push_back(j - i);
            end
            if (o_l[i]) oo.push_back(i);
            if (s_l[i]) osent.push_back(i);
            if (!en_l[i] && d_l[i] != 2'b00) nidle++;
        end
        checks++;
        if (os.size() != es.size()) begin
            errors++;
            $display("FAIL %s frame_count got %0d required %0d", name, os.size(), es.size());
        end
        for (int f = 0; f < es.size() && f < os.size(); f++) begin
            checks++;
            if (os[f] !== es[f]) begin
                errors++;
                $display("FAIL %s frame%0d_start got %0d required %0d", name, f, os[f], es[f]);
            end
            checks++;
            if (ol[f] !== flen) begin
                errors++;
                $display("FAIL %s frame%0d_tx_en_len got %0d required %0d", name, f, ol[f], flen);
            end
            build_frame(enq[f], er[f]);
            nbad = 0;
            first = -1;
            for (int i = 0; i < flen && os[f] + i < MAXC; i++) begin
                eb = exp_f[(i / step) / 4];
                ed = eb[2 * ((i / step) % 4) +: 2];
                if (d_l[os[f] + i] !== ed) begin
                    if (first < 0) first = i;
                    nbad++;
                end
            end
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL %s frame%0d_dibits %0d wrong, first at offset %0d (byte %0d)", name, f, nbad,
                         first, (first / step) / 4);
            end
            for (int b = 0; b < 8; b++) got[8 * b +: 8] = obs_byte(os[f], step, 36 + b);
            checks++;
            if (got !== er[f]) begin
                errors++;
                $display("FAIL %s frame%0d_reltime got %h required %h", name, f, got, er[f]);
            end
            checks++;
            if (b_l[os[f] + dlen - 1] !== 1'b1 || b_l[os[f] + dlen] !== 1'b0) begin
                errors++;
                $display("FAIL %s frame%0d_busy_fall got %b%b required 10 at clk %0d", name, f,
                         b_l[os[f] + dlen - 1], b_l[os[f] + dlen], os[f] + dlen);
            end
        end
        nmis = (osent.size() != es.size()) ? 1 : 0;
        for (int f = 0; f < osent.size() && f < es.size(); f++) if (osent[f] != es[f] + flen) nmis++;
        checks++;
        if (nmis != 0) begin
            errors++;
            $display("FAIL %s soc_sent got %0d pulses (first %0d) required %0d (first %0d)", name,
                     osent.size(), osent.size() ? osent[0] : -1, es.size(), es.size() ? es[0] + flen : -1);
        end
        nmis = (oo.size() != eo.size()) ? 1 : 0;
        for (int f = 0; f < oo.size() && f < eo.size(); f++) if (oo[f] != eo[f]) nmis++;
        checks++;
        if (nmis != 0) begin
            errors++;
            $display("FAIL %s overrun got %0d pulses (first %0d) required %0d (first %0d)", name,
                     oo.size(), oo.size() ? oo[0] : -1, eo.size(), eo.size() ? eo[0] : -1);
        end
        checks++;
        if (nidle !== 0) begin
            errors++;
            $display("FAIL %s idle_txd got %0d nonzero clks required 0", name, nidle);
        end
    endtask

    task automatic test_reset;
        rst = 0;
        enable = 1;
        fast_eth = 1;
        cycle_len = 10;
        repeat (3) @(negedge clk);
        checks += 5;
        if (rm_tx_en !== 1'b0) begin errors++; $display("FAIL reset rm_tx_en got %b required 0", rm_tx_en); end
        if (rm_tx_data !== 2'b00) begin errors++; $display("FAIL reset rm_tx_data got %b required 00", rm_tx_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b required 0", busy); end
        if (soc_sent !== 1'b0) begin errors++; $display("FAIL reset soc_sent got %b required 0", soc_sent); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b required 0", overrun); end
    endtask

    task automatic test_single_fast;
        nt_base = {$urandom, $urandom};
        run_check("single_fast", 1000, $urandom, 1, 1, 0);
    endtask

    task automatic test_periods;
        run_check("periods", 1000, 32'd1000000, 1, 3, 1);
    endtask

    task automatic test_overrun;
        run_check("overrun", 200, $urandom, 1, 6, 1);
    endtask

    task automatic test_zero_len;
        run_check("zero_len", 0, $urandom, 1, 340, 1);
    endtask

    task automatic test_slow;
        nt_base = {$urandom, $urandom};
        run_check("slow", 5000, $urandom, 0, 1, 0);
    endtask

    task automatic test_nettime;
        logic [7:0] b;
        nt_base = 64'h0123456789ABCDEF;
        run_check("nettime", 1000, $urandom, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            b = obs_byte(1, 1, 28 + i);
            checks++;
            if (b !== nt_bytes[i]) begin
                errors++;
                $display("FAIL nettime byte%0d got %h required %h", 20 + i, b, nt_bytes[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        rst = 0;
        enable = 1;
        fast_eth = 1;
        cycle_len = 1000;
        cycle_ns = $urandom | 32'd1;
        net_time = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        #2 rst = 1;
        wait_cyc(100);
        checks++;
        if (rm_tx_en !== 1'b1) begin errors++; $display("FAIL mid_reset pre tx_en got %b required 1", rm_tx_en); end
        rst = 0;
        #1;
        checks += 3;
        if (rm_tx_en !== 1'b0) begin errors++; $display("FAIL mid_reset rm_tx_en got %b required 0", rm_tx_en); end
        if (rm_tx_data !== 2'b00) begin errors++; $display("FAIL mid_reset rm_tx_data got %b required 00", rm_tx_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy got %b required 0", busy); end
        nt_base = {$urandom, $urandom};
        run_check("after_reset", 1000, $urandom | 32'd1, 1, 1, 0);
    endtask

    initial begin
        test_reset;
        test_single_fast;
        test_periods;
        test_overrun;
        test_zero_len;
        test_slow;
        test_nettime;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/soc_frame_gen.md
# soc_frame_gen

Originating-side Powerlink SoC (Start of Cycle) frame generator for the managing-node end of the RMII link. Issues a fixed-layout SoC frame every `cycle_len` clocks, inserting a sampled NetTime and an internally accumulated RelativeTime, and appends a CRC-32 FCS. It drives RMII transmit dibits directly. Downstream hubs receive and retransmit the frames it produces.

## Interface
- `SRC_MAC`, default 48'h00_50_C2_00_00_F0: source MAC, byte 0 = MSB.
- `clk`  in  1: single system/RMII clock (50 MHz).
- `rst`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: run cycle timer; low holds timer at 0.
- `fast_eth`  in  1: 1 = 100 Mb/s (one dibit/clk), 0 = 10 Mb/s (dibit held 10 clk).
- `cycle_len`  in  32: SoC period in clk; 0 treated as 1.
- `cycle_ns`  in  32: RelativeTime increment per period.
- `net_time`  in  64: NetTime, sampled on trigger.
- `rm_tx_en`  out  1: RMII TX_EN.
- `rm_tx_data`  out  2: RMII TXD.
- `busy`  out  1: high from trigger+1 until end of IFG.
- `soc_sent`  out  1: 1-clk pulse, frame finished.
- `overrun`  out  1: 1-clk pulse, trigger dropped because `busy`.

## Operation
- Period counter: when `enable`=1, triggers at count 0, counts 0..`cycle_len`-1, wraps. The first trigger occurs on the first clk with `enable`=1. `enable`=0 zeroes the counter; an in-flight frame completes.
- Each trigger: RelativeTime register += `cycle_ns` (64-bit, wraps mod 2^64) after its value is latched. The first SoC carries 0. The increment occurs on overrun too.
- Trigger while `busy`: no frame, `overrun` pulse, and NetTime/RelativeTime are not latched into the frame buffer.
- Frame bytes, each sent as dibits LSB first ([1:0],[3:2],[5:4],[7:6]):
  - 7×0x55, 0xD5.
  - Data bytes 0–59:
    - 0–5: 01 11 1E 00 00 01.
    - 6–11: SRC_MAC MSB first.
    - 12–13: 88 AB.
    - 14: 0x01.
    - 15: 0xFF.
    - 16: 0xF0.
    - 17–19: 0x00.
    - 20–27: NetTime little-endian.
    - 28–35: RelativeTime little-endian.
    - 36–59: 0x00.
  - FCS: 4 bytes.
- FCS: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, over data bytes 0–59, 2 bits per step. The transmitted value is ~crc, low byte first.
- FSM states:
  - IDLE → PRE on trigger & !busy.
  - PRE: 8 bytes → DATA.
  - DATA: 60 bytes → FCS.
  - FCS: 4 bytes → IFG.
  - IFG: 12 byte times, `rm_tx_en`=0 → IDLE.
- Dibit slot = 1 clk (fast) or 10 clk (slow). `fast_eth` is sampled at trigger and held for the frame.
- Reset values: all outputs 0; FSM IDLE; counters 0; RelativeTime 0. Reset mid-frame drops `rm_tx_en` immediately, with no `soc_sent` pulse.

## Timing
- Trigger at clk T (registered) → `rm_tx_en`=1 and first 0x55 dibit (2'b01) at T+1; `busy`=1 at T+1.
- Fast: 288 dibits, so `rm_tx_en` is high T+1..T+288.
  - `soc_sent` pulse at T+289.
  - IFG of 48 clk; `busy` falls at T+337.
- Slow: every slot ×10, so `rm_tx_en` is high T+1..T+2880.
  - `soc_sent` pulse at T+2881.
  - `busy` falls at T+3361.
- `rm_tx_data`=0 whenever `rm_tx_en`=0.
- A trigger coinciding with the last IFG clk counts as busy and gives `overrun`. A trigger on the clk `busy` is low starts a frame.

## Structure
- Shared package `epl_pkg`:
  - SoC multicast MAC, EtherType 0x88AB, msg type SoC, node IDs 0xFF/0xF0.
  - CRC poly/init.
  - Byte offsets (NETTIME_OFS=20, RELTIME_OFS=28, DATA_LEN=60).
  - Preamble/IFG byte counts.
- Sub-module `crc32_dibit`: registered CRC-32 state with clear, enable, 2-bit data in, 32-bit state out. It is reused by the receive-side checkers.

## Test plan
- Reset, `fast_eth`=1, `enable`=1, `cycle_len`=1000 → `rm_tx_en` high at clk 1 for 288 clk. Decoded frame has preamble/SFD, the fixed header above, RelativeTime 0, and FCS matching the software CRC-32. `soc_sent` pulses at clk 289.
- `cycle_ns`=1000000, run 3 periods → RelativeTime fields 0, 1000000, 2000000; SoC starts at clk 1, 1001, 2001.
- `cycle_len`=200, fast → every second trigger gives an `overrun` pulse; frames are spaced 400 clk; RelativeTime advances 2×`cycle_ns` between sent frames.
- `fast_eth`=0, `cycle_len`=5000 → each dibit held 10 clk; `rm_tx_en` lasts 2880 clk; `busy` falls at T+3361.
- `net_time`=64'h0123456789ABCDEF at trigger → bytes 20–27 are EF CD AB 89 67 45 23 01.
- Assert `rst` low mid-DATA → `rm_tx_en`/`rm_tx_data`/`busy` go to 0 immediately. After release with `enable`=1, a fresh frame carries RelativeTime 0.
